col_frame_sequencer: RTL and testbench

- Frame-level controller for the column-streaming pixel pipeline (RAM column source -> grey stage -> blur stage).
- Issues the stage-chain init pulse and acts as the final consumer of the last stage's req/rdy/last_col handshake.
- Counts accepted columns, flags frame completion and column-count mismatches, and runs a stall watchdog.
- Sits between the top-level control inputs (KEY/SW) and the pipeline tail.

---
 rtl/col_frame_sequencer.sv | 179 +++++++++++++++++
 tb/tb_col_frame_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/col_frame_sequencer.sv
// Frame-level controller for the column-streaming pixel pipeline: init pulse, tail handshake,
// column counting, frame/error flags and stall watchdog. Define COL_FRAME_SEQ_AUTO_RESTART_EN
// to restart a new frame automatically one cycle after each clean frame completes.
module col_frame_sequencer #(
  parameter int unsigned NUM_COLS    = 256,
  parameter int unsigned INIT_CYCLES = 2,
  parameter int unsigned TIMEOUT     = 1023,
  parameter int unsigned CW          = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          sink_ready,
  input  logic          stage_rdy,
  input  logic          stage_last,
  output logic          init,
  output logic          sink_req,
  output logic          col_accept,
  output logic [CW-1:0] col_idx,
  output logic          busy,
  output logic          frame_done,
  output logic          err_count,
  output logic          err_timeout,
  output logic [15:0]   frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [3:0]    INIT_LOAD = 4'(INIT_CYCLES);
  localparam logic [CW:0]   COLS_W    = (CW+1)'(NUM_COLS);
  localparam logic [CW-1:0] LAST_IDX  = CW'(NUM_COLS - 1);
  localparam logic [16:0]   TIMEOUT_W = 17'(TIMEOUT);

  state_e        state_q, state_d;
  logic [3:0]    init_cnt_q, init_cnt_d;
  logic [CW-1:0] col_cnt_q, col_cnt_d;
  logic [15:0]   wdog_q, wdog_d;
  logic          init_q, init_d;
  logic          busy_q, busy_d;
  logic          col_accept_q, col_accept_d;
  logic [CW-1:0] col_idx_q, col_idx_d;
  logic          frame_done_q, frame_done_d;
  logic          err_count_q, err_count_d;
  logic          err_timeout_q, err_timeout_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;

  logic          accept;
  logic          stall;
  logic          launch;
  logic          done_exit;

  assign sink_req = (state_q == S_RUN) && sink_ready;
  assign accept   = sink_req && stage_rdy;
  assign stall    = sink_req && !stage_rdy;

`ifdef COL_FRAME_SEQ_AUTO_RESTART_EN
  assign done_exit = 1'b1;
`else
  assign done_exit = start;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    col_cnt_d     = col_cnt_q;
    wdog_d        = wdog_q;
    col_accept_d  = 1'b0;
    col_idx_d     = col_idx_q;
    frame_done_d  = 1'b0;
    err_count_d   = err_count_q;
    err_timeout_d = err_timeout_q;
    frame_cnt_d   = frame_cnt_q;
    launch        = 1'b0;

    unique case (state_q)
      S_IDLE: launch = start;
      S_INIT: begin
        if (init_cnt_q <= 4'd1) state_d = S_RUN;
        else                    init_cnt_d = init_cnt_q - 4'd1;
      end
      S_RUN: begin
        if (accept) begin
          col_accept_d = 1'b1;
          col_idx_d    = col_cnt_q;
          col_cnt_d    = col_cnt_q + 1'b1;
          wdog_d       = '0;
          if (stage_last) begin
            if (({1'b0, col_cnt_q} + 1'b1) == COLS_W) begin
              state_d      = S_DONE;
              frame_done_d = 1'b1;
              frame_cnt_d  = frame_cnt_q + 16'd1;
            end else begin
              state_d     = S_ERR;
              err_count_d = 1'b1;
            end
          end else if (col_cnt_q == LAST_IDX) begin
            // Column beyond the frame without last_col: overrun.
            state_d     = S_ERR;
            err_count_d = 1'b1;
          end
        end else if (stall) begin
          if (({1'b0, wdog_q} + 17'd1) == TIMEOUT_W) begin
            state_d       = S_ERR;
            err_timeout_d = 1'b1;
            wdog_d        = '0;
          end else begin
            wdog_d = wdog_q + 16'd1;
          end
        end else begin
          wdog_d = '0;
        end
      end
      S_DONE:  launch = done_exit;
      S_ERR:   launch = start;
      default: state_d = S_IDLE;
    endcase

    if (launch) begin
      state_d       = S_INIT;
      init_cnt_d    = INIT_LOAD;
      col_cnt_d     = '0;
      wdog_d        = '0;
      err_count_d   = 1'b0;
      err_timeout_d = 1'b0;
    end

    init_d = (state_d == S_INIT);
    busy_d = (state_d == S_INIT) || (state_d == S_RUN);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      init_cnt_q    <= '0;
      col_cnt_q     <= '0;
      wdog_q        <= '0;
      init_q        <= 1'b0;
      busy_q        <= 1'b0;
      col_accept_q  <= 1'b0;
      col_idx_q     <= '0;
      frame_done_q  <= 1'b0;
      err_count_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      col_cnt_q     <= col_cnt_d;
      wdog_q        <= wdog_d;
      init_q        <= init_d;
      busy_q        <= busy_d;
      col_accept_q  <= col_accept_d;
      col_idx_q     <= col_idx_d;
      frame_done_q  <= frame_done_d;
      err_count_q   <= err_count_d;
      err_timeout_q <= err_timeout_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign init        = init_q;
  assign busy        = busy_q;
  assign col_accept  = col_accept_q;
  assign col_idx     = col_idx_q;
  assign frame_done  = frame_done_q;
  assign err_count   = err_count_q;
  assign err_timeout = err_timeout_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_col_frame_sequencer.sv
// Directed self-checking bench for col_frame_sequencer with NUM_COLS=4, INIT_CYCLES=2, TIMEOUT=8.
module tb_col_frame_sequencer;

  localparam int unsigned NUM_COLS    = 4;
  localparam int unsigned INIT_CYCLES = 2;
  localparam int unsigned TIMEOUT     = 8;
  localparam int unsigned CW          = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          sink_ready = 1'b0;
  logic          stage_rdy = 1'b0;
  logic          stage_last = 1'b0;
  logic          init;
  logic          sink_req;
  logic          col_accept;
  logic [CW-1:0] col_idx;
  logic          busy;
  logic          frame_done;
  logic          err_count;
  logic          err_timeout;
  logic [15:0]   frame_cnt;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clock = ~clock;

  col_frame_sequencer #(
    .NUM_COLS(NUM_COLS), .INIT_CYCLES(INIT_CYCLES), .TIMEOUT(TIMEOUT), .CW(CW)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .sink_ready(sink_ready),
    .stage_rdy(stage_rdy), .stage_last(stage_last), .init(init), .sink_req(sink_req),
    .col_accept(col_accept), .col_idx(col_idx), .busy(busy), .frame_done(frame_done),
    .err_count(err_count), .err_timeout(err_timeout), .frame_cnt(frame_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; sink_ready = 1'b0; stage_rdy = 1'b0; stage_last = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".init"},        32'(init),        0);
    check({tag, ".sink_req"},    32'(sink_req),    0);
    check({tag, ".col_accept"},  32'(col_accept),  0);
    check({tag, ".col_idx"},     32'(col_idx),     0);
    check({tag, ".busy"},        32'(busy),        0);
    check({tag, ".frame_done"},  32'(frame_done),  0);
    check({tag, ".err_count"},   32'(err_count),   0);
    check({tag, ".err_timeout"}, 32'(err_timeout), 0);
    check({tag, ".frame_cnt"},   32'(frame_cnt),   0);
  endtask

  // Leaves the bench one cycle into RUN.
  task automatic start_frame();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running want=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic saw_accept;

    // Reset state and init timing.
    do_reset();
    check_idle("reset");
    sink_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("init_c1", 32'(init), 1);
    check("busy_c1", 32'(busy), 1);
    check("sreq_c1", 32'(sink_req), 0);
    step();
    check("init_c2", 32'(init), 1);
    check("sreq_c2", 32'(sink_req), 0);
    step();
    check("init_c3", 32'(init), 0);
    check("sreq_c3", 32'(sink_req), 1);
    check("busy_c3", 32'(busy), 1);

    // Clean frame, stage_rdy every 3rd cycle; stage_last without stage_rdy is ignored.
    for (int k = 0; k < 4; k++) begin
      stage_rdy = 1'b0; stage_last = 1'b1;
      step();
      check("frm_stall_acc", 32'(col_accept), 0);
      step();
      check("frm_stall_acc", 32'(col_accept), 0);
      stage_rdy = 1'b1; stage_last = (k == 3);
      step();
      check("frm_acc", 32'(col_accept), 1);
      check("frm_idx", 32'(col_idx), 32'(k));
      check("frm_done", 32'(frame_done), (k == 3) ? 1 : 0);
    end
    stage_rdy = 1'b0; stage_last = 1'b0;
    check("frm_cnt", 32'(frame_cnt), 1);
    check("frm_busy", 32'(busy), 0);
    check("frm_errc", 32'(err_count), 0);
    step();
    check("frm_done_pulse", 32'(frame_done), 0);
    check("frm_acc_pulse", 32'(col_accept), 0);
`ifdef COL_FRAME_SEQ_AUTO_RESTART_EN
    check("auto_init", 32'(init), 1);
    check("auto_busy", 32'(busy), 1);
`else
    check("hold_init", 32'(init), 0);
    check("hold_busy", 32'(busy), 0);
    step();
    step();
    check("hold_init2", 32'(init), 0);
    check("hold_cnt", 32'(frame_cnt), 1);
`endif

    // Early stage_last on the 3rd accept.
    do_reset();
    sink_ready = 1'b1;
    start_frame();
    stage_rdy = 1'b1;
    step();
    step();
    stage_last = 1'b1;
    step();
    stage_rdy = 1'b0; stage_last = 1'b0;
    check("short_idx", 32'(col_idx), 2);
    check("short_errc", 32'(err_count), 1);
    check("short_done", 32'(frame_done), 0);
    check("short_fcnt", 32'(frame_cnt), 0);
    check("short_busy", 32'(busy), 0);
    step();
    check("err_sreq", 32'(sink_req), 0);
    check("err_hold", 32'(err_count), 1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("err_clr", 32'(err_count), 0);
    check("err_reinit", 32'(init), 1);

    // Overrun: NUM_COLS accepts with no stage_last.
    do_reset();
    sink_ready = 1'b1;
    start_frame();
    stage_rdy = 1'b1;
    repeat (3) step();
    check("ovr_pre_errc", 32'(err_count), 0);
    check("ovr_pre_busy", 32'(busy), 1);
    step();
    stage_rdy = 1'b0;
    check("ovr_idx", 32'(col_idx), 3);
    check("ovr_errc", 32'(err_count), 1);
    check("ovr_busy", 32'(busy), 0);

    // Watchdog expires after exactly TIMEOUT stalled RUN cycles.
    do_reset();
    sink_ready = 1'b1;
    start_frame();
    repeat (7) step();
    check("wd_pre", 32'(err_timeout), 0);
    check("wd_pre_busy", 32'(busy), 1);
    step();
    check("wd_fire", 32'(err_timeout), 1);
    check("wd_busy", 32'(busy), 0);
    check("wd_errc", 32'(err_count), 0);

    // Accept on the would-be timeout cycle wins.
    do_reset();
    sink_ready = 1'b1;
    start_frame();
    repeat (7) step();
    stage_rdy = 1'b1;
    step();
    stage_rdy = 1'b0;
    check("wd_race_acc", 32'(col_accept), 1);
    check("wd_race_idx", 32'(col_idx), 0);
    check("wd_race_to", 32'(err_timeout), 0);
    check("wd_race_busy", 32'(busy), 1);

    // stage_rdy without sink_ready: no accept, no watchdog; start while busy ignored.
    do_reset();
    start_frame();
    stage_rdy = 1'b1;
    start = 1'b1;
    saw_accept = 1'b0;
    repeat (20) begin
      step();
      if (col_accept || init) saw_accept = 1'b1;
    end
    start = 1'b0;
    check("nrdy_acc", 32'(saw_accept), 0);
    check("nrdy_to", 32'(err_timeout), 0);
    check("nrdy_busy", 32'(busy), 1);
    check("nrdy_sreq", 32'(sink_req), 0);
    sink_ready = 1'b1;
    #1;
    check("nrdy_sreq_up", 32'(sink_req), 1);
    step();
    check("nrdy_acc_up", 32'(col_accept), 1);
    check("nrdy_idx_up", 32'(col_idx), 0);

    // Reset mid-RUN after two accepts.
    do_reset();
    sink_ready = 1'b1;
    start_frame();
    stage_rdy = 1'b1;
    step();
    step();
    check("mid_idx", 32'(col_idx), 1);
    reset = 1'b1;
    step();
    check_idle("mid_reset");
    reset = 1'b0;
    sink_ready = 1'b0;
    stage_rdy = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
